// File: rtl/parity_frame_tx.sv
// parity_frame_tx
// Serial transmitter for the ALSU parity path. On a valid/ready handshake it
// latches one 4-bit operand (A or B, chosen by Sel), computes its parity bit
// and shifts out a 7-bit frame: start(0), d0..d3 (LSB first), parity, stop(1).
//
// Parameters
//   BIT_CYCLES  clock cycles per serial bit (>= 1)
//   PARITY_ODD  0 = even parity (^data), 1 = odd parity (~^data)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   A, B         4-bit operands
//   Sel          operand select: 0 = A, 1 = B
//   start_valid  request to send one frame
//   start_ready  high while idle (request can be accepted)
//   tx_out       registered serial line, idles high
//   parity_out   {3'b000, p} of the latched operand, held until next accept
//   done         one-cycle pulse when the frame finishes (STOP -> IDLE)
module parity_frame_tx #(
  parameter int BIT_CYCLES = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Sel,
  input  logic       start_valid,
  output logic       start_ready,
  output logic       tx_out,
  output logic [3:0] parity_out,
  output logic       done
);

  // Counter is wide enough for BIT_CYCLES-1; at least one bit for BIT_CYCLES=1.
  localparam int            CW      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [1:0]    idx_q,   idx_d;
  logic [3:0]    data_q,  data_d;
  logic          par_q,   par_d;
  logic          tx_q,    tx_d;
  logic          done_q,  done_d;

  logic          bit_end;
  logic [1:0]    idx_nxt;

  function automatic logic calc_parity(input logic [3:0] d);
    return (PARITY_ODD != 0) ? ~^d : ^d;
  endfunction

  assign bit_end = (cnt_q == CNT_MAX);
  assign idx_nxt = idx_q + 2'd1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (start_valid) begin
          data_d  = Sel ? B : A;
          par_d   = calc_parity(Sel ? B : A);
          state_d = S_START;
          idx_d   = 2'd0;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
          idx_d   = 2'd0;
          tx_d    = data_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 2'd3) begin
            state_d = S_PARITY;
            idx_d   = 2'd0;
            tx_d    = par_q;
          end else begin
            idx_d = idx_nxt;
            tx_d  = data_q[idx_nxt];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      data_q  <= 4'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign start_ready = (state_q == S_IDLE);
  assign tx_out      = tx_q;
  assign parity_out  = {3'b000, par_q};
  assign done        = done_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx. Instance 0: BIT_CYCLES=1, even parity.
// Instance 1: BIT_CYCLES=3, odd parity. Expected frame bits and parity_out
// values are pushed to a scoreboard when a request is driven and popped as
// the DUT produces each bit / end of frame.
module tb_parity_frame_tx;

  logic       clk;
  logic       rst;
  logic [3:0] a_in   [2];
  logic [3:0] b_in   [2];
  logic [1:0] sel;
  logic [1:0] sv;
  logic [1:0] ready;
  logic [1:0] tx;
  logic [3:0] par    [2];
  logic [1:0] done;

  int cyc = 0;
  int npass = 0;
  int ntotal = 0;

  logic       q_tx  [$];
  logic [3:0] q_par [$];

  parity_frame_tx #(.BIT_CYCLES(1), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst(rst), .A(a_in[0]), .B(b_in[0]), .Sel(sel[0]),
    .start_valid(sv[0]), .start_ready(ready[0]), .tx_out(tx[0]),
    .parity_out(par[0]), .done(done[0])
  );

  parity_frame_tx #(.BIT_CYCLES(3), .PARITY_ODD(1)) u_dut1 (
    .clk(clk), .rst(rst), .A(a_in[1]), .B(b_in[1]), .Sel(sel[1]),
    .start_valid(sv[1]), .start_ready(ready[1]), .tx_out(tx[1]),
    .parity_out(par[1]), .done(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic check_idle(input int inst, input string tag);
    check({tag, " tx"},    {3'b0, tx[inst]},    4'b0001);
    check({tag, " ready"}, {3'b0, ready[inst]}, 4'b0001);
    check({tag, " done"},  {3'b0, done[inst]},  4'b0000);
  endtask

  // Drives one request (called away from a clock edge), then checks every
  // cycle of the frame and the end-of-frame edge. Returns #1 after edge
  // k+7*bc, with the accept edge's cycle number in k_cyc.
  task automatic send_frame(input int inst, input int bc, input logic [3:0] a_v,
                            input logic [3:0] b_v, input logic sel_v,
                            input bit keep_valid, input bit disturb,
                            output int k_cyc);
    logic [3:0] d;
    logic       p;
    logic       exp_bit;
    d = sel_v ? b_v : a_v;
    p = (inst == 1) ? ~^d : ^d;
    a_in[inst] = a_v;
    b_in[inst] = b_v;
    sel[inst]  = sel_v;
    sv[inst]   = 1'b1;
    q_tx.push_back(1'b0);
    for (int i = 0; i < 4; i++) q_tx.push_back(d[i]);
    q_tx.push_back(p);
    q_tx.push_back(1'b1);
    q_par.push_back({3'b000, p});

    @(posedge clk); #1;
    k_cyc = cyc;
    if (!keep_valid) sv[inst] = 1'b0;
    check("accept done low", {3'b0, done[inst]}, 4'b0000);
    for (int b = 0; b < 7; b++) begin
      exp_bit = q_tx.pop_front();
      for (int c = 0; c < bc; c++) begin
        if (disturb && b == 2 && c == 0) begin
          a_in[inst] = ~a_v;
          b_in[inst] = ~b_v;
          sel[inst]  = ~sel_v;
        end
        check($sformatf("tx bit%0d", b), {3'b0, tx[inst]}, {3'b0, exp_bit});
        check($sformatf("busy ready bit%0d", b), {3'b0, ready[inst]}, 4'b0000);
        check($sformatf("busy done bit%0d", b), {3'b0, done[inst]}, 4'b0000);
        @(posedge clk); #1;
      end
    end
    check("end done",   {3'b0, done[inst]},  4'b0001);
    check("end ready",  {3'b0, ready[inst]}, 4'b0001);
    check("end tx",     {3'b0, tx[inst]},    4'b0001);
    check("parity_out", par[inst],           q_par.pop_front());
  endtask

  initial begin
    int k1, k2, kd;
    rst = 1'b0;
    sv  = 2'b00;
    sel = 2'b00;
    for (int i = 0; i < 2; i++) begin
      a_in[i] = 4'd0;
      b_in[i] = 4'd0;
    end

    // 1. asynchronous reset mid-cycle, before any clock edge
    #3 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_idle(i, $sformatf("reset%0d", i));
      check($sformatf("reset%0d parity", i), par[i], 4'b0000);
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);

    // 2. operand A, even parity
    send_frame(0, 1, 4'b1011, 4'b0000, 1'b0, 1'b0, 1'b0, kd);
    @(posedge clk); #1;
    check("done one cycle", {3'b0, done[0]}, 4'b0000);

    // 3. operand B, even parity, A ignored
    send_frame(0, 1, 4'b1111, 4'b0110, 1'b1, 1'b0, 1'b0, kd);

    // 4. odd parity, 3 cycles/bit, inputs disturbed mid-frame
    send_frame(1, 3, 4'b0000, 4'b1010, 1'b0, 1'b0, 1'b1, kd);
    check("odd parity_out", par[1], 4'b0001);

    // 5. back-to-back with start_valid held high
    send_frame(0, 1, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, k1);
    send_frame(0, 1, 4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0, k2);
    check("b2b spacing", 4'(k2 - k1), 4'd8);

    // 6a. sweep all A then all B operands
    for (int v = 0; v < 16; v++)
      send_frame(0, 1, 4'(v), 4'(~v), 1'b0, 1'b0, 1'b0, kd);
    for (int v = 0; v < 16; v++)
      send_frame(0, 1, 4'($urandom_range(0, 15)), 4'(v), 1'b1, 1'b0, 1'b0, kd);

    // 6b. reset during DATA aborts the frame
    a_in[0] = 4'b1010;
    sel[0]  = 1'b0;
    sv[0]   = 1'b1;
    @(posedge clk); #1;
    sv[0] = 1'b0;
    check("abort start bit", {3'b0, tx[0]}, 4'b0000);
    @(posedge clk); #1;
    check("abort d0", {3'b0, tx[0]}, 4'b0000);
    @(posedge clk); #1;
    check("abort d1", {3'b0, tx[0]}, 4'b0001);
    #2 rst = 1'b1;
    #1;
    check_idle(0, "abort");
    check("abort parity", par[0], 4'b0000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort no done", {3'b0, done[0]}, 4'b0000);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check_idle(0, "post-abort idle");
    end
    send_frame(0, 1, 4'b0111, 4'b0000, 1'b0, 1'b0, 1'b0, kd);

    // idle with start_valid low stays high
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_idle(0, "idle0");
      check_idle(1, "idle1");
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
